iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Execute-stage ALU that consumes the 4-bit operation code from the ALU control decoder, plus operands A/B from the register-file/immediate mux.
- Produces a registered result and zero flag for writeback and the branch unit.
- Logic/arithmetic ops complete in one cycle. Shifts run on an iterative barrel-free shifter, SHIFT_STEP bits per cycle.
- Valid/ready handshakes on both sides, so the core can stall on multi-cycle shifts.

Parameters:
- WIDTH, 32, operand/result width; legal value 32 only (shamt is 5 bits).
- SHIFT_STEP, 1, bits shifted per cycle in SHIFT state; legal 1, 2, 4, 8.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept operation this cycle
- alu_ctrl  input  4  operation code from ALU control
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B; shift amount = op_b[4:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered (result == 0)
- busy  output  1  high in SHIFT state

Behaviour:
- Op codes:
  - 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B.
  - 0011 slt: signed, result 1 if $signed(A) < $signed(B), else 0.
  - 0100 A<<B[4:0]; 0101 A>>B[4:0] (logical, zero fill).
  - 0111 A^B; 1000 ~A; 1001 pass B; 1010 pass A.
  - Any other code behaves as 0010 (add).
- Add/sub wrap modulo 2^WIDTH; no overflow output.
- States: IDLE, SHIFT, DONE.
- in_ready = rst_n && (state==IDLE || (state==DONE && out_ready)). The block accepts a new op in the same cycle the previous result is consumed.
- Accept (in_valid && in_ready):
  - Operands and code are latched.
  - Non-shift op: result computed and registered. Next state DONE, out_valid=1 on the following cycle (latency 1).
  - Shift with shamt==0: result=A, next state DONE (latency 1).
  - Shift with shamt>0: next state SHIFT. Working register = A, remaining = shamt.
- SHIFT, each cycle:
  - Working register shifts by min(SHIFT_STEP, remaining); remaining decrements by the same amount.
  - When remaining reaches 0, result = working value and next state DONE.
  - Total latency = ceil(shamt/SHIFT_STEP)+1 cycles from accept to out_valid. Example: STEP=1, shamt=31 gives 32 cycles.
- DONE:
  - out_valid=1. result and zero are held stable until out_ready.
  - out_ready && !in_valid: go to IDLE, out_valid drops the next cycle.
  - out_ready && in_valid: accept the new op (see Accept).
- in_valid during SHIFT is ignored (in_ready=0); upstream must hold it.
- out_ready while out_valid=0 has no effect.
- zero is computed from the final result only, registered together with result.
- Reset (rst_n low at a clock edge):
  - state=IDLE, out_valid=0, result=0, zero=0, busy=0, remaining=0.
  - Any in-flight shift is discarded, with no output.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- busy=1 exactly while state==SHIFT.

Test Plan:
- Reset, then add: rst_n low 2 cycles then high; code 0010, A=0x7FFFFFFF, B=1 -> next cycle out_valid=1, result=0x80000000, zero=0; reset values all 0 during reset.
- Sub to zero for beq: code 0110, A=B=0x1234 -> result=0, zero=1, latency 1. Code 0011, A=0xFFFFFFFF, B=1 -> result=1 (signed). Undefined code 1111, A=3, B=4 -> result=7.
- Iterative shift, STEP=1: code 0100, A=1, B=31 -> busy high 31 cycles, in_ready=0, out_valid on cycle 32, result=0x80000000. Code 0101, A=0x80000000, B=0x20 (shamt 0) -> result=0x80000000 after 1 cycle.
- Back-pressure and back-to-back: out_ready held 0 for 5 cycles -> result and out_valid stable. Assert out_ready with a new op (0111, A=0xF0F0, B=0xFF00) in the same cycle -> accepted that cycle, next result=0x0FF0 with out_valid continuous.
- Reset mid-shift: start 0100, B=20, assert rst_n low on cycle 5 -> next cycle out_valid=0, busy=0. After release, a new add completes normally with no stale result.
- STEP=4 variant: code 0101, A=0xFFFFFFFF, B=9 -> 3 SHIFT cycles, result=0x007FFFFF on cycle 4.

Source files
------------

// File: rtl/iter_alu.sv
// ----------------------------------------------------------------------------
// iter_alu
// Execute-stage ALU with valid/ready handshakes on both sides. Logic and
// arithmetic ops complete in one cycle; shifts run on an iterative shifter
// that moves the working value at most SHIFT_STEP bits per cycle, stalling
// the core through the handshake while the shift is in flight.
//
// Ports
//   clk        core clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation presented by upstream
//   in_ready   block can accept an operation this cycle
//   alu_ctrl   4-bit operation code from the ALU control decoder
//   op_a       operand A
//   op_b       operand B (shift amount = op_b[4:0])
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       registered (result == 0)
//   busy       high while an iterative shift is in progress
// ----------------------------------------------------------------------------
module iter_alu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_NOTA = 4'b1000;
    localparam logic [3:0] OP_PASB = 4'b1001;
    localparam logic [3:0] OP_PASA = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               out_valid_q;

    logic               accept_c;
    logic               is_shift_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [WIDTH-1:0]   alu_res_c;
    logic [SHAMT_W-1:0] step_c;
    logic [SHAMT_W-1:0] rem_d;
    logic [WIDTH-1:0]   work_d;

    // Ready path is combinational so a result can be consumed and a new op
    // accepted in the same cycle.
    assign in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept_c  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = (state_q == S_SHIFT);

    assign shamt_c    = op_b[SHAMT_W-1:0];
    assign is_shift_c = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL);

    // Single-cycle datapath; shift codes yield A, which is the correct
    // answer for a zero shift amount and otherwise unused.
    always_comb begin
        alu_res_c = op_a + op_b;
        unique case (alu_ctrl)
            OP_AND:  alu_res_c = op_a & op_b;
            OP_OR:   alu_res_c = op_a | op_b;
            OP_ADD:  alu_res_c = op_a + op_b;
            OP_SUB:  alu_res_c = op_a - op_b;
            OP_SLT:  alu_res_c = WIDTH'($signed(op_a) < $signed(op_b));
            OP_SLL:  alu_res_c = op_a;
            OP_SRL:  alu_res_c = op_a;
            OP_XOR:  alu_res_c = op_a ^ op_b;
            OP_NOTA: alu_res_c = ~op_a;
            OP_PASB: alu_res_c = op_b;
            OP_PASA: alu_res_c = op_a;
            default: alu_res_c = op_a + op_b;
        endcase
    end

    // Per-cycle shift step: min(SHIFT_STEP, remaining), so the final step
    // never overshoots the requested amount.
    always_comb begin
        step_c = (rem_q < SHAMT_W'(SHIFT_STEP)) ? rem_q : SHAMT_W'(SHIFT_STEP);
        rem_d  = rem_q - step_c;
        work_d = (op_q == OP_SLL) ? (work_q << step_c) : (work_q >> step_c);
    end

    // Control FSM and all registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            work_q      <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept_c) begin
            op_q <= alu_ctrl;
            if (is_shift_c && (shamt_c != '0)) begin
                state_q     <= S_SHIFT;
                work_q      <= op_a;
                rem_q       <= shamt_c;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= S_DONE;
                result_q    <= alu_res_c;
                zero_q      <= (alu_res_c == '0);
                out_valid_q <= 1'b1;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_SHIFT: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= S_DONE;
                        result_q    <= work_d;
                        zero_q      <= (work_d == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Result is held until consumed; no new op this cycle.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// ----------------------------------------------------------------------------
// tb_iter_alu
// Directed bench for iter_alu: a SHIFT_STEP=1 instance carries most of the
// sequence, a SHIFT_STEP=4 instance covers the multi-bit step and its
// final partial step. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_iter_alu;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  alu_ctrl4;
    logic [31:0] op_a4;
    logic [31:0] op_b4;
    logic        out_valid4;
    logic        out_ready4;
    logic [31:0] result4;
    logic        zero4;
    logic        busy4;

    int vectors;
    int miscompares;

    iter_alu #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    iter_alu #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .alu_ctrl  (alu_ctrl4),
        .op_a      (op_a4),
        .op_b      (op_b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .result    (result4),
        .zero      (zero4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One op on the STEP=1 instance from IDLE, then drain back to IDLE.
    task automatic run_op(input string tag, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int n;
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 64) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 64) begin tick(); n++; end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " result"}, result, exp);
        chk({tag, " zero"}, 32'(zero), 32'(exp == 32'd0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Shift on the STEP=4 instance; checks latency and busy cycle count.
    task automatic run_shift4(input string tag, input logic [3:0] c,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_cnt;
        in_valid4 = 1'b1; alu_ctrl4 = c; op_a4 = a; op_b4 = b; out_ready4 = 1'b0;
        tick();
        in_valid4 = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid4 && lat < 64) begin
            if (busy4) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, " result"}, result4, exp);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int rdy_seen;

        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; alu_ctrl = 4'd0; op_a = '0; op_b = '0; out_ready = 1'b0;
        in_valid4 = 1'b0; alu_ctrl4 = 4'd0; op_a4 = '0; op_b4 = '0; out_ready4 = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        // Add with wrap into the sign bit, latency 1
        in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'h7FFF_FFFF; op_b = 32'd1;
        tick();
        in_valid = 1'b0;
        chk("add out_valid", 32'(out_valid), 32'd1);
        chk("add result", result, 32'h8000_0000);
        chk("add zero", 32'(zero), 32'd0);
        chk("done in_ready w/o out_ready", 32'(in_ready), 32'd0);

        // Back-to-back: sub to zero, slt signed, undefined code as add
        out_ready = 1'b1;
        in_valid = 1'b1; alu_ctrl = 4'b0110; op_a = 32'h1234; op_b = 32'h1234;
        tick();
        chk("sub out_valid", 32'(out_valid), 32'd1);
        chk("sub result", result, 32'd0);
        chk("sub zero", 32'(zero), 32'd1);
        alu_ctrl = 4'b0011; op_a = 32'hFFFF_FFFF; op_b = 32'd1;
        tick();
        chk("slt result", result, 32'd1);
        chk("slt zero", 32'(zero), 32'd0);
        alu_ctrl = 4'b1111; op_a = 32'd3; op_b = 32'd4;
        tick();
        chk("undef result", result, 32'd7);
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Remaining single-cycle ops
        run_op("and",   4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        run_op("or",    4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        run_op("nota",  4'b1000, 32'h0000_FFFF, 32'h1111_1111, 32'hFFFF_0000);
        run_op("passb", 4'b1001, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_op("passa", 4'b1010, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
        run_op("slt pos<neg", 4'b0011, 32'd5, 32'hFFFF_FFFF, 32'd0);
        run_op("slt min<0", 4'b0011, 32'h8000_0000, 32'd0, 32'd1);
        run_op("add wrap0", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("sub neg", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF);
        run_op("undef1100", 4'b1100, 32'd10, 32'd20, 32'd30);
        run_op("srl4 hibits", 4'b0101, 32'h0000_00F0, 32'hFFFF_FFE4, 32'h0000_000F);

        // Long shift with STEP=1: upstream holds a different op meanwhile
        in_valid = 1'b1; alu_ctrl = 4'b0100; op_a = 32'd1; op_b = 32'd31;
        tick();
        alu_ctrl = 4'b1001; op_b = 32'hDEAD_0000;
        lat = 1;
        busy_cnt = 0;
        rdy_seen = 0;
        while (!out_valid && lat < 64) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_seen++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("sll31 latency", 32'(lat), 32'd32);
        chk("sll31 busy cycles", 32'(busy_cnt), 32'd31);
        chk("sll31 in_ready during shift", 32'(rdy_seen), 32'd0);
        chk("sll31 result", result, 32'h8000_0000);
        chk("sll31 busy after", 32'(busy), 32'd0);

        // Zero shift amount accepted while consuming the previous result
        out_ready = 1'b1;
        in_valid = 1'b1; alu_ctrl = 4'b0101; op_a = 32'h8000_0000; op_b = 32'h20;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("srl0 out_valid", 32'(out_valid), 32'd1);
        chk("srl0 result", result, 32'h8000_0000);
        chk("srl0 busy", 32'(busy), 32'd0);

        // Back-pressure: result and out_valid hold for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp result", result, 32'h8000_0000);
        end

        // Consume and accept a new op in the same cycle
        out_ready = 1'b1;
        in_valid = 1'b1; alu_ctrl = 4'b0111; op_a = 32'h0000_F0F0; op_b = 32'h0000_FF00;
        #1;
        chk("b2b in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("xor out_valid", 32'(out_valid), 32'd1);
        chk("xor result", result, 32'h0000_0FF0);
        tick();
        chk("xor drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of a shift discards it
        in_valid = 1'b1; alu_ctrl = 4'b0100; op_a = 32'd1; op_b = 32'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midshift busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midshift rst out_valid", 32'(out_valid), 32'd0);
        chk("midshift rst busy", 32'(busy), 32'd0);
        chk("midshift rst result", result, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd5; op_b = 32'd6;
        tick();
        in_valid = 1'b0;
        chk("post-rst add out_valid", 32'(out_valid), 32'd1);
        chk("post-rst add result", result, 32'd11);
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid || busy) break;
        end
        chk("no stale out_valid", 32'(out_valid), 32'd0);
        chk("no stale busy", 32'(busy), 32'd0);
        out_ready = 1'b0;

        // STEP=4 instance: partial final step and latency
        run_shift4("s4 srl9", 4'b0101, 32'hFFFF_FFFF, 32'd9, 32'h007F_FFFF, 4);
        run_shift4("s4 sll3", 4'b0100, 32'd1, 32'd3, 32'd8, 2);
        run_shift4("s4 srl31", 4'b0101, 32'hFFFF_FFFF, 32'd31, 32'd1, 9);
        run_shift4("s4 sll4", 4'b0100, 32'h0000_000F, 32'd4, 32'h0000_00F0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
